// File: rtl/free_list_pkg.sv
// Shared rename-stage definitions: physical/architectural register sizing,
// tag types, uop fields and the slot prefix-popcount helper.
package free_list_pkg;

  localparam int FL_NUM_PREGS = 64;
  localparam int FL_NUM_AREGS = 15;
  localparam int FL_WIDTH     = 3;
  localparam int TAG_W        = 6;
  localparam int CNT_W        = TAG_W + 1;

  typedef logic [TAG_W-1:0] preg_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] areg;
    preg_t      pdst;
    preg_t      psrc1;
    preg_t      psrc2;
  } uop_t;

  // Number of set bits of v strictly below bit position n.
  function automatic logic [CNT_W-1:0] prefix_pop(input logic [FL_WIDTH-1:0] v, input int n);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < FL_WIDTH; j++) begin
      if (j < n && v[j]) acc = acc + CNT_W'(1);
    end
    return acc;
  endfunction

endpackage

// File: rtl/free_list_mem.sv
// Free-tag storage: 64x6 array with combinational read ports and
// clocked write ports; reset loads the tags not held by architectural state.
module free_list_mem
  import free_list_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS,
  parameter int NUM_AREGS = FL_NUM_AREGS,
  parameter int PORTS     = FL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0][TAG_W-1:0] rd_addr,
  output logic [PORTS-1:0][TAG_W-1:0] rd_data,
  input  logic [PORTS-1:0]            wr_en,
  input  logic [PORTS-1:0][TAG_W-1:0] wr_addr,
  input  logic [PORTS-1:0][TAG_W-1:0] wr_data
);

  logic [TAG_W-1:0] mem [NUM_PREGS];

  // NOTE: this array is reset on purpose; its power-on contents are the
  // initial free list, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem[i] <= (i < NUM_PREGS - NUM_AREGS) ? TAG_W'(NUM_AREGS + i) : '0;
      end
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (wr_en[p]) mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_data[p] = mem[rd_addr[p]];
    end
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of tags with all-or-nothing
// multi-slot allocation and compacted multi-slot release.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS,
  parameter int NUM_AREGS = FL_NUM_AREGS,
  parameter int WIDTH     = FL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            alloc_req,
  output logic                        alloc_ready,
  output logic [WIDTH-1:0][TAG_W-1:0] alloc_preg,
  input  logic [WIDTH-1:0]            free_valid,
  input  logic [WIDTH-1:0][TAG_W-1:0] free_preg,
  output logic [CNT_W-1:0]            free_count,
  output logic                        overflow_err
);

  logic [TAG_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] n_alloc, n_free, granted, space, n_written, a_off, f_off;
  logic             overflow_hit;

  logic [WIDTH-1:0][TAG_W-1:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [WIDTH-1:0]            wr_en;

  free_list_mem #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS),
    .PORTS     (WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // NOTE: every output of this block gets a value before any conditional
  // logic, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    n_alloc     = prefix_pop(alloc_req, WIDTH);
    n_free      = prefix_pop(free_valid, WIDTH);
    alloc_ready = rst && (count >= n_alloc);
    granted     = alloc_ready ? n_alloc : '0;
    // Room for releases counts the entries being handed out this cycle.
    space       = CNT_W'(NUM_PREGS) - count + granted;
    n_written   = '0;
    a_off       = '0;
    f_off       = '0;
    alloc_preg  = '0;
    rd_addr     = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_addr[i] = head + TAG_W'(i);
      a_off      = prefix_pop(alloc_req, i);
      if (alloc_req[i] && alloc_ready) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (a_off == CNT_W'(j)) alloc_preg[i] = rd_data[j];
        end
      end
      f_off      = prefix_pop(free_valid, i);
      wr_en[i]   = free_valid[i] && (f_off < space);
      wr_addr[i] = tail + f_off[TAG_W-1:0];
      wr_data[i] = free_preg[i];
      if (wr_en[i]) n_written = n_written + CNT_W'(1);
    end
    overflow_hit = n_free > space;
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values sampled at the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= TAG_W'(NUM_PREGS - NUM_AREGS);
      count        <= CNT_W'(NUM_PREGS - NUM_AREGS);
      overflow_err <= 1'b0;
    end else begin
      head         <= head + granted[TAG_W-1:0];
      tail         <= tail + n_written[TAG_W-1:0];
      count        <= count - granted + n_written;
      overflow_err <= overflow_err | overflow_hit;
    end
  end

  assign free_count = count;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed table, corner sequences and
// randomized traffic against a queue-based model of the free tag FIFO.
module tb_free_list;

  logic             clk;
  logic             rst;
  logic [2:0]       alloc_req;
  logic             alloc_ready;
  logic [2:0][5:0]  alloc_preg;
  logic [2:0]       free_valid;
  logic [2:0][5:0]  free_preg;
  logic [6:0]       free_count;
  logic             overflow_err;

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: free tags in FIFO order, tags held outside the list.
  int q[$];
  int outst[$];
  bit m_ovf;

  logic            e_ready;
  logic [2:0][5:0] e_preg;
  logic            s_ready;
  logic [2:0][5:0] s_preg;

  typedef struct {
    logic [2:0]      areq;
    logic [2:0]      fv;
    logic [2:0][5:0] fp;
    logic            exp_ready;
    logic [2:0][5:0] exp_preg;
    int              exp_count;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    outst.delete();
    for (int t = 15; t < 64; t++) q.push_back(t);
    for (int t = 0; t < 15; t++) outst.push_back(t);
    m_ovf = 1'b0;
  endfunction

  function automatic void model_expect(input logic [2:0] areq);
    int k;
    int t;
    k = 0;
    e_ready = (q.size() >= $countones(areq));
    e_preg = '0;
    if (e_ready) begin
      for (int i = 0; i < 3; i++) begin
        if (areq[i]) begin
          t = q[k];
          e_preg[i] = 6'(t);
          k++;
        end
      end
    end
  endfunction

  function automatic void model_commit(input logic [2:0] areq, input logic [2:0] fv,
                                       input logic [2:0][5:0] fp);
    int t;
    if (q.size() >= $countones(areq)) begin
      for (int i = 0; i < 3; i++) begin
        if (areq[i]) begin
          t = q.pop_front();
          outst.push_back(t);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (fv[i]) begin
        if (q.size() < 64) q.push_back(int'(fp[i]));
        else m_ovf = 1'b1;
      end
    end
  endfunction

  // One clock cycle: drive, sample mid-cycle, optionally compare with model, commit.
  task automatic apply(input logic [2:0] areq, input logic [2:0] fv,
                       input logic [2:0][5:0] fp, input bit chk);
    alloc_req  = areq;
    free_valid = fv;
    free_preg  = fp;
    @(negedge clk);
    model_expect(areq);
    s_ready = alloc_ready;
    s_preg  = alloc_preg;
    if (chk) begin
      check("ready", 64'(alloc_ready), 64'(e_ready));
      check("preg", 64'(alloc_preg), 64'(e_preg));
      check("count", 64'(free_count), 64'(q.size()));
      check("ovf", 64'(overflow_err), 64'(m_ovf));
    end
    @(posedge clk);
    model_commit(areq, fv, fp);
    #1;
  endtask

  task automatic do_reset();
    alloc_req  = 3'b111;
    free_valid = '0;
    free_preg  = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", 64'(free_count), 64'd49);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd0);
    check("rst_preg", 64'(alloc_preg), 64'd0);
    model_reset();
    rst = 1'b1;
    alloc_req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hist [64];
    int idx;
    int guard;
    int t;
    logic [2:0] areq, fv;
    logic [2:0][5:0] fp;

    tbl[0] = '{areq: 3'b111, fv: 3'b000, fp: '0, exp_ready: 1'b1,
               exp_preg: {6'd17, 6'd16, 6'd15}, exp_count: 46};
    tbl[1] = '{areq: 3'b101, fv: 3'b000, fp: '0, exp_ready: 1'b1,
               exp_preg: {6'd19, 6'd0, 6'd18}, exp_count: 44};
    tbl[2] = '{areq: 3'b000, fv: 3'b001, fp: {6'd0, 6'd0, 6'd3}, exp_ready: 1'b1,
               exp_preg: '0, exp_count: 45};
    tbl[3] = '{areq: 3'b010, fv: 3'b110, fp: {6'd5, 6'd4, 6'd0}, exp_ready: 1'b1,
               exp_preg: {6'd0, 6'd20, 6'd0}, exp_count: 46};
    tbl[4] = '{areq: 3'b011, fv: 3'b000, fp: '0, exp_ready: 1'b1,
               exp_preg: {6'd0, 6'd22, 6'd21}, exp_count: 44};
    tbl[5] = '{areq: 3'b100, fv: 3'b111, fp: {6'd8, 6'd7, 6'd6}, exp_ready: 1'b1,
               exp_preg: {6'd23, 6'd0, 6'd0}, exp_count: 46};

    // Directed table from reset.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      apply(tbl[r].areq, tbl[r].fv, tbl[r].fp, 1'b0);
      check("tbl_ready", 64'(s_ready), 64'(tbl[r].exp_ready));
      check("tbl_preg", 64'(s_preg), 64'(tbl[r].exp_preg));
      check("tbl_count", 64'(free_count), 64'(tbl[r].exp_count));
    end

    // Sparse request from reset: slot 1 gets nothing, head moves by two.
    do_reset();
    apply(3'b101, '0, '0, 1'b1);
    check("sparse_s0", 64'(s_preg[0]), 64'd15);
    check("sparse_s1", 64'(s_preg[1]), 64'd0);
    check("sparse_s2", 64'(s_preg[2]), 64'd16);
    apply(3'b001, '0, '0, 1'b1);
    check("sparse_head", 64'(s_preg[0]), 64'd17);

    // Drain to two free tags: 3-wide request refused, 2-wide granted.
    do_reset();
    for (int c = 0; c < 15; c++) apply(3'b111, '0, '0, 1'b1);
    apply(3'b011, '0, '0, 1'b1);
    check("drain_cnt", 64'(free_count), 64'd2);
    apply(3'b111, '0, '0, 1'b1);
    check("short_ready", 64'(s_ready), 64'd0);
    check("short_preg", 64'(s_preg), 64'd0);
    check("short_hold", 64'(free_count), 64'd2);
    apply(3'b011, '0, '0, 1'b1);
    check("fit_ready", 64'(s_ready), 64'd1);
    apply(3'b001, '0, '0, 1'b1);
    check("empty_ready", 64'(s_ready), 64'd0);
    apply(3'b000, '0, '0, 1'b1);
    check("idle_ready", 64'(s_ready), 64'd1);

    // Simultaneous alloc and free at count 10; freed tags come out last.
    do_reset();
    for (int c = 0; c < 13; c++) apply(3'b111, '0, '0, 1'b1);
    apply(3'b111, 3'b011, {6'd0, 6'd41, 6'd40}, 1'b1);
    check("mix_count", 64'(free_count), 64'd9);
    apply(3'b111, '0, '0, 1'b1);
    apply(3'b111, '0, '0, 1'b1);
    apply(3'b001, '0, '0, 1'b1);
    apply(3'b011, '0, '0, 1'b1);
    check("late_40", 64'(s_preg[0]), 64'd40);
    check("late_41", 64'(s_preg[1]), 64'd41);

    // Release overflow at count 63, sticky error, then mid-cycle reset.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      fp = {6'(3 * c + 2), 6'(3 * c + 1), 6'(3 * c)};
      apply(3'b000, 3'b111, fp, 1'b1);
    end
    apply(3'b000, 3'b011, {6'd0, 6'd13, 6'd12}, 1'b1);
    check("near_full", 64'(free_count), 64'd63);
    apply(3'b000, 3'b111, {6'd21, 6'd20, 6'd14}, 1'b1);
    check("full_count", 64'(free_count), 64'd64);
    check("ovf_set", 64'(overflow_err), 64'd1);
    for (int c = 0; c < 21; c++) apply(3'b111, '0, '0, 1'b1);
    apply(3'b001, '0, '0, 1'b1);
    check("kept_first", 64'(s_preg[0]), 64'd14);
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    alloc_req = 3'b111;
    #3 rst = 1'b0;
    #1;
    check("mid_count", 64'(free_count), 64'd49);
    check("mid_ovf", 64'(overflow_err), 64'd0);
    check("mid_ready", 64'(alloc_ready), 64'd0);
    check("mid_preg", 64'(alloc_preg), 64'd0);
    do_reset();
    apply(3'b111, '0, '0, 1'b1);
    check("post_rst", 64'(s_preg), 64'({6'd17, 6'd16, 6'd15}));

    // Randomized traffic wrapping the pointers many times, then conservation.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      areq = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      fv = '0;
      fp = '0;
      for (int s = 0; s < 3; s++) begin
        if (outst.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = $urandom_range(0, outst.size() - 1);
          fv[s] = 1'b1;
          fp[s] = 6'(outst[idx]);
          outst.delete(idx);
        end
      end
      apply(areq, fv, fp, 1'b1);
    end
    for (int i = 0; i < 64; i++) hist[i] = 0;
    for (int i = 0; i < outst.size(); i++) begin
      t = outst[i];
      hist[t]++;
    end
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      guard++;
      areq = (q.size() >= 3) ? 3'b111 : ((q.size() == 2) ? 3'b011 : 3'b001);
      apply(areq, '0, '0, 1'b1);
      if (s_ready) begin
        for (int s = 0; s < 3; s++) begin
          if (areq[s]) hist[int'(s_preg[s])]++;
        end
      end
    end
    check("drained", 64'(free_count), 64'd0);
    for (int i = 0; i < 64; i++) check("conserve", 64'(hist[i]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64, physical register count (6-bit tags); SHALL be fixed at 64 in this revision.
REQ-002 Parameter NUM_AREGS, default 15, architectural registers mapped at reset.
REQ-003 Parameter WIDTH, default 3, rename slots per cycle.
REQ-004 clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low (rst).
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 alloc_req  input  [2:0]  per-slot request for one free physical register (slot 0 oldest).
REQ-007 alloc_ready  output  1  all requested slots granted this cycle.
REQ-008 alloc_preg  output  [2:0][5:0]  granted tag per slot; valid only where alloc_req[i] && alloc_ready.
REQ-009 free_valid  input  [2:0]  per-slot release of a physical register (from commit).
REQ-010 free_preg  input  [2:0][5:0]  tag being released per slot.
REQ-011 free_count  output  [6:0]  registered count of free tags.
REQ-012 overflow_err  output  1  sticky; a release was dropped because the list was full.

Function
REQ-013 List SHALL be a 64-entry circular FIFO of 6-bit tags: head (6b), tail (6b), count (7b).
REQ-014 n_alloc = popcount(alloc_req); alloc_ready SHALL be 1 iff count >= n_alloc (combinational, same cycle).
REQ-015 Allocation SHALL be all-or-nothing: if alloc_ready=0 no entry is consumed and head is unchanged.
REQ-016 Requesting slots SHALL receive consecutive entries in slot order: k-th set bit of alloc_req gets mem[head+k] (mod 64).
REQ-017 alloc_preg for non-requesting slots SHALL be 0.
REQ-018 alloc_preg SHALL be combinational from registered state (zero latency); head advances by n_alloc at the clock edge when granted.
REQ-019 Releases SHALL be compacted in slot order: k-th set bit of free_valid writes mem[tail+k]; tail advances by the number written.
REQ-020 Tags released in cycle N SHALL NOT be allocatable before cycle N+1 (alloc_ready uses registered count).
REQ-021 Next count = count - granted_allocs + written_frees; simultaneous alloc and free in one cycle SHALL be supported.
REQ-022 Release overflow: if count - granted_allocs + n_free > 64, only the lowest-slot frees that fit SHALL be written, the rest dropped, and overflow_err set until reset.
REQ-023 Pointers SHALL wrap modulo 64 with no bubble; allocation and release crossing entry 63->0 in one cycle SHALL be correct.
REQ-024 alloc_req=0 SHALL yield alloc_ready=1, no state change.
REQ-025 The block SHALL NOT check for duplicate or out-of-range releases beyond REQ-022.

Reset
REQ-026 On rst low, asynchronously: mem[i]=NUM_AREGS+i for i=0..48, mem[49..63]=0, head=0, tail=49, count=49, overflow_err=0.
REQ-027 During reset, alloc_ready SHALL be 0 and alloc_preg all 0; reset mid-operation SHALL discard in-flight requests.
REQ-028 Reset release is synchronous to clk; first grant possible on the first rising edge after rst goes high.

Structure
REQ-029 NUM_PREGS, NUM_AREGS, WIDTH and tag width SHALL live in the shared defines file alongside the uop field definitions.
REQ-030 Storage SHALL be a sub-module free_list_mem: 64x6, 3 combinational read ports, 3 write ports, async reset per REQ-026.
REQ-031 Slot-compaction offsets (prefix popcounts) SHALL be computed in free_list; no other sub-modules.

Verification
REQ-032 Reset, then alloc_req=3'b111 -> alloc_ready=1, alloc_preg={17,16,15}; next cycle free_count=46.
REQ-033 alloc_req=3'b101 from reset -> slot0=15, slot2=16, slot1=0; head=2.
REQ-034 Drain to count=2, alloc_req=3'b111 -> alloc_ready=0, count stays 2; alloc_req=3'b011 -> granted.
REQ-035 Same cycle alloc 3 and free {40,41} at count=10 -> next free_count=9; 40,41 not granted that cycle, granted later in FIFO order.
REQ-036 Drive head/tail through 63->0 wrap with 3-wide alloc and free for 100 cycles -> no lost/duplicated tags; multiset of free tags conserved.
REQ-037 At count=63 free 3 tags -> first tag written, two dropped, free_count=64, overflow_err=1; assert rst low mid-cycle -> outputs return to REQ-026 values immediately.
